// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment display path.
//   - Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
//   - AN_OFF turns every (active-low) anode off.
//   - scan_state_e is the per-slot BLANK/SHOW state of the scan controller.
package display_scan_ctrl_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/display_scan_ctrl_bcd_to_7seg.sv
// BCD to seven-segment decoder, purely combinational.
//   bcd  in  4  BCD digit; 10..15 are not digits and show blank
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_7seg
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a four-digit seven-segment display.
// Each digit owns a slot of REFRESH_DIV cycles; the first BLANK_CYCLES of a
// slot keep all anodes off so the segment register settles on the new digit
// before its anode lights (no ghosting). Digits flagged in blink_mask are
// kept dark while blink_phase is high.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           scan enable; low blanks the display and restarts at digit 0
//   mux_out      BCD digit from the external 4-to-1 mux for mux_sel
//   blink_mask   bit i set: digit i blinks
//   dp_mask      bit i set: decimal point lit on digit i
//   mux_sel      current digit index to the external mux (0 = rightmost)
//   an           anodes, active-low
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   dbg_state    current BLANK/SHOW state, for observation only
//
// Handshake: none; all inputs are sampled every clock, outputs are registered.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  mux_out,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [1:0]  mux_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output scan_state_e dbg_state
);

  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_SHOW  = CNT_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  scan_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_dec;
  logic               dp_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;

  bcd_to_7seg u_dec (
    .bcd (mux_out),
    .seg (seg_dec)
  );

  // Next-state and anode decode. The anode register follows the next state,
  // so it falls on the edge cnt reaches BLANK_CYCLES and rises on the wrap
  // edge together with mux_sel. Blink uses the current phase register, so a
  // phase toggle shows up one edge later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    an_d    = AN_OFF;
    if (!en) begin
      cnt_d   = '0;
      idx_d   = 2'd0;
      state_d = ST_BLANK;
    end else begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = (idx_q == 2'd3) ? 2'd0 : idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      case (state_q)
        ST_BLANK: if (cnt_d == CNT_SHOW) state_d = ST_SHOW;
        ST_SHOW:  if (cnt_q == CNT_MAX)  state_d = ST_BLANK;
        default:  state_d = ST_BLANK;
      endcase
    end
    if (state_d == ST_SHOW && !(blink_phase_q && blink_mask[idx_q]))
      an_d = ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_dec;
      dp_q    <= ~dp_mask[idx_q];
    end
  end

  // Blink timebase runs regardless of en so the blink rhythm stays steady
  // while the display is switched off and on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 1'b1;
    end
  end

  assign mux_sel   = idx_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2,
// BLINK_DIV=32. The external 4-to-1 mux is modelled by digits[mux_sel].
module tb_display_scan_ctrl;
  import display_scan_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  digits [4];
  logic [3:0]  mux_out;
  logic [1:0]  mux_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  scan_state_e dbg_state;

  assign mux_out = digits[mux_sel];

  display_scan_ctrl #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2),
    .BLINK_DIV    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mux_out    (mux_out),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .mux_sel    (mux_sel),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Expected segment codes for the digits loaded into the mux model.
  logic [6:0] exp_seg [4];
  logic [3:0] an_on   [4];

  initial begin
    int cnt, idx, phase_prev;
    logic [3:0] an_exp;

    an_on[0] = 4'hE; an_on[1] = 4'hD; an_on[2] = 4'hB; an_on[3] = 4'h7;
    digits[0] = 4'd4; digits[1] = 4'd3; digits[2] = 4'd2; digits[3] = 4'd1;
    exp_seg[0] = 7'h19; exp_seg[1] = 7'h30; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;

    // Reset held with the clock running.
    en = 1'b1;
    tick(3);
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_an",      32'(an),      32'hF);
    check("rst_seg",     32'(seg),     32'h7F);
    check("rst_dp",      32'(dp),      32'd1);

    // Release on a falling edge; posedge k after release gives cnt=k%8,
    // idx=(k/8)%4 and blink_phase=(k/32)%2.
    rst_n = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if (k > 0) tick(1);
      cnt = k % 8;
      idx = (k / 8) % 4;
      phase_prev = (k > 0) ? ((k - 1) / 32) % 2 : 0;
      an_exp = 4'hF;
      if (cnt >= 2 && !(phase_prev == 1 && blink_mask[idx]))
        an_exp = an_on[idx];
      check($sformatf("scan_an_k%0d", k),      32'(an),      32'(an_exp));
      check($sformatf("scan_mux_sel_k%0d", k), 32'(mux_sel), 32'(idx));
      if (cnt >= 1) begin
        check($sformatf("scan_seg_k%0d", k), 32'(seg), 32'(exp_seg[idx]));
        check($sformatf("scan_dp_k%0d", k),  32'(dp),  32'(!dp_mask[idx]));
      end
      // Stimulus changes applied before the next edge.
      if (k == 31) blink_mask = 4'b0010;
      if (k == 95) begin
        blink_mask = 4'b0000;
        digits[2]  = 4'hB;
        exp_seg[2] = 7'h7F;
        dp_mask    = 4'b0100;
      end
    end

    // Now at slot 2, cnt=5: invalid digit blank, dp lit, anode 2 on.
    check("slot2_seg", 32'(seg), 32'h7F);
    check("slot2_dp",  32'(dp),  32'd0);
    check("slot2_an",  32'(an),  32'hB);

    // en drop mid-slot.
    en = 1'b0;
    tick(1);
    check("endrop_an",      32'(an),      32'hF);
    check("endrop_mux_sel", 32'(mux_sel), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check($sformatf("enlow_an_%0d", i),      32'(an),      32'hF);
      check($sformatf("enlow_mux_sel_%0d", i), 32'(mux_sel), 32'd0);
    end
    en = 1'b1;
    tick(1);
    check("enrise_blank1", 32'(an), 32'hF);
    tick(1);
    check("enrise_show_an",  32'(an),      32'hE);
    check("enrise_show_sel", 32'(mux_sel), 32'd0);

    // From digit 0 cnt=2 to digit 3 cnt=7, then drop en exactly on the wrap.
    tick(29);
    check("prewrap_an",  32'(an),      32'h7);
    check("prewrap_sel", 32'(mux_sel), 32'd3);
    en = 1'b0;
    tick(1);
    check("wrapdrop_an",  32'(an),      32'hF);
    check("wrapdrop_sel", 32'(mux_sel), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("wrapdrop_hold_an_%0d", i), 32'(an), 32'hF);
    end
    en = 1'b1;
    tick(1);
    check("wrap_enrise_blank", 32'(an), 32'hF);
    tick(1);
    check("wrap_enrise_show", 32'(an), 32'hE);

    // Move into digit 1 SHOW (cnt=4), then assert reset between edges.
    tick(10);
    check("presrst_an",  32'(an),      32'hD);
    check("presrst_sel", 32'(mux_sel), 32'd1);
    check("presrst_seg", 32'(seg),     32'h30);
    #2;
    rst_n = 1'b0;
    #1;
    check("asyncrst_mux_sel", 32'(mux_sel), 32'd0);
    check("asyncrst_an",      32'(an),      32'hF);
    check("asyncrst_seg",     32'(seg),     32'h7F);
    check("asyncrst_dp",      32'(dp),      32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("postrst_an", 32'(an), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
